// File: rtl/riscv_mmio_responder.sv
// riscv_mmio_responder
// Memory-mapped peripheral on the processor data port. Exposes a byte TX FIFO,
// a read-only STATUS word, a sticky EXIT/halt register and a free-running
// cycle counter inside a 16-byte window. One outstanding request at a time:
// a request is accepted when req_valid && req_ready, and exactly one response
// pulse follows in the next cycle.
module riscv_mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_EXIT   = 2'd2;
  localparam logic [1:0] REG_CYCLE  = 2'd3;

  // STATUS only has a 4-bit occupancy field, so larger counts clamp to 15.
  function automatic logic [3:0] sat_count4(input logic [CNT_W-1:0] c);
    logic [3:0] r;
    if (32'(c) > 32'd15) begin
      r = 4'hF;
    end else begin
      r = 4'(c);
    end
    return r;
  endfunction

  // Registered state
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;
  logic             halt_r;
  logic [31:0]      exit_code_r;
  logic [31:0]      cycle_r;

  // Combinational decode / control
  logic             in_window_s;
  logic             aligned_s;
  logic             addr_err_s;
  logic [1:0]       reg_sel_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             tx_push_req_s;
  logic             req_ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             exit_wr_s;
  logic [31:0]      load_data_s;
  logic [7:0]       tx_data_s;

  // Address decode, stall rule and accept/push/pop strobes.
  always_comb begin
    in_window_s   = (req_addr[31:4] == BASE_ADDR[31:4]);
    aligned_s     = (req_addr[1:0] == 2'b00);
    addr_err_s    = !(in_window_s && aligned_s);
    reg_sel_s     = req_addr[3:2];
    fifo_full_s   = (count_r == DEPTH_C);
    fifo_empty_s  = (count_r == {CNT_W{1'b0}});
    tx_push_req_s = req_we && !addr_err_s && (reg_sel_s == REG_TX);
    if (reset) begin
      req_ready_s = 1'b0;
    end else begin
      // Only a TX store into a full FIFO waits; everything else just waits
      // for the previous response slot to drain.
      req_ready_s = !rsp_valid_r && !(tx_push_req_s && fifo_full_s);
    end
    accept_s  = req_valid && req_ready_s;
    push_s    = accept_s && tx_push_req_s;
    pop_s     = !fifo_empty_s && tx_ready;
    exit_wr_s = accept_s && req_we && !addr_err_s && (reg_sel_s == REG_EXIT);
  end

  // Load data as seen in the accept cycle (state before this edge's updates).
  always_comb begin
    load_data_s = 32'h0000_0000;
    if (!req_we && !addr_err_s) begin
      case (reg_sel_s)
        REG_TX:     load_data_s = 32'h0000_0000;
        REG_STATUS: load_data_s = {24'h00_0000, sat_count4(count_r), 2'b00,
                                   fifo_empty_s, fifo_full_s};
        REG_EXIT:   load_data_s = exit_code_r;
        REG_CYCLE:  load_data_s = cycle_r;
        default:    load_data_s = 32'h0000_0000;
      endcase
    end else begin
      load_data_s = 32'h0000_0000;
    end
  end

  // Head-of-FIFO byte; forced to zero while the FIFO is empty.
  always_comb begin
    if (fifo_empty_s) begin
      tx_data_s = 8'h00;
    end else begin
      tx_data_s = fifo_mem_r[rd_ptr_r];
    end
  end

  // FIFO storage: written on push only, contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= req_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Single-cycle response pulse following every accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= accept_s;
      rsp_rdata_r <= accept_s ? load_data_s : 32'h0000_0000;
      rsp_err_r   <= accept_s && addr_err_s;
    end
  end

  // Sticky halt and last EXIT value; only reset clears halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_r      <= 1'b0;
      exit_code_r <= 32'h0000_0000;
    end else begin
      if (exit_wr_s) begin
        halt_r      <= 1'b1;
        exit_code_r <= req_wdata;
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign tx_valid  = !fifo_empty_s;
  assign tx_data   = tx_data_s;
  assign halt      = halt_r;
  assign exit_code = exit_code_r;

endmodule

// File: tb/tb_riscv_mmio_responder.sv
// Testbench for riscv_mmio_responder: directed scenarios followed by random
// requests, all checked cycle by cycle against a queue-based reference model.
module tb_riscv_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [31:0] exit_code;

  riscv_mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  byte unsigned m_q[$];
  logic [31:0]  m_cycle = 32'h0;
  logic [31:0]  m_exit = 32'h0;
  logic         m_halt = 1'b0;
  logic         m_pend = 1'b0;
  logic         m_acc = 1'b0;
  bit           rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Returns 1 when the address hits an aligned register; off is its byte offset.
  function automatic bit m_decode(input logic [31:0] a, output int off);
    off = int'(a - BASE);
    return ((a / 32'd16) == (BASE / 32'd16)) && ((a % 32'd4) == 32'd0);
  endfunction

  function automatic logic [31:0] m_status();
    int c = m_q.size();
    int v;
    v = ((c > 15) ? 15 : c) * 16;
    if (c == 0) v = v + 2;
    if (c == DEPTH) v = v + 1;
    return 32'(v);
  endfunction

  // One clock: predict from current inputs, advance model, compare outputs.
  task automatic tick();
    int off;
    bit ok, acc, pop, exp_ready, is_tx_store;
    logic [31:0] rd;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    #1;
    ok = m_decode(req_addr, off);
    is_tx_store = req_we && ok && (off == 0);
    exp_ready = !m_pend && !(is_tx_store && (m_q.size() == DEPTH));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = req_valid && exp_ready;
    pop = (m_q.size() > 0) && tx_ready;
    rd = 32'h0;
    if (acc && ok && !req_we) begin
      case (off)
        4:       rd = m_status();
        8:       rd = m_exit;
        12:      rd = m_cycle;
        default: rd = 32'h0;
      endcase
    end
    @(posedge clk);
    m_cycle = m_cycle + 32'd1;
    if (pop) void'(m_q.pop_front());
    if (acc && is_tx_store) m_q.push_back(req_wdata[7:0]);
    if (acc && ok && req_we && (off == 8)) begin
      m_halt = 1'b1;
      m_exit = req_wdata;
    end
    m_pend = acc;
    m_acc  = acc;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(acc));
    check("rsp_err", 32'(rsp_err), 32'(acc && !ok));
    check("rsp_rdata", rsp_rdata, rd);
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
    check("halt", 32'(halt), 32'(m_halt));
    check("exit_code", exit_code, m_exit);
  endtask

  // Present a request until accepted (bounded), then run the response cycle.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int n = 0;
    rdata = 32'h0;
    err = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    m_acc = 1'b0;
    while (!m_acc && n < 40) begin
      tick();
      n++;
      if (m_acc) begin
        rdata = rsp_rdata;
        err = rsp_err;
      end
    end
    check("accept_timeout", 32'(m_acc), 32'd1);
    req_valid = 1'b0; req_we = 1'b0;
    tick();
  endtask

  // Assert reset now, check cleared outputs, release on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    m_q.delete();
    m_cycle = 32'h0; m_exit = 32'h0; m_halt = 1'b0; m_pend = 1'b0; m_acc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          r;
    logic [31:0] a;

    do_reset();

    // Idle after reset, then a CYCLE load accepted on the 5th edge reads 4.
    repeat (4) tick();
    do_req(1'b0, BASE + 32'hC, 32'h0, rd, er);
    check("cycle_after_reset", rd, 32'd4);
    check("cycle_err", 32'(er), 32'd0);

    // Three bytes through the FIFO with the consumer always ready.
    tx_ready = 1'b1;
    do_req(1'b1, BASE, 32'h41, rd, er);
    do_req(1'b1, BASE, 32'h42, rd, er);
    do_req(1'b1, BASE, 32'h43, rd, er);
    tick();
    do_req(1'b0, BASE + 32'h4, 32'h0, rd, er);
    check("status_empty", rd, 32'h0000_0002);

    // Fill the FIFO with the consumer stalled, then the 5th store must wait.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_req(1'b1, BASE, 32'h60 + 32'(i), rd, er);
    do_req(1'b0, BASE + 32'h4, 32'h0, rd, er);
    check("status_full", rd, 32'h0000_0041);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h64;
    repeat (3) begin
      tick();
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("stall_release", 32'(req_ready), 32'd1);
    tick();
    check("stall_accept", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0; req_we = 1'b0;
    tick();
    tx_ready = 1'b1;
    repeat (6) tick();
    tx_ready = 1'b0;

    // EXIT register: halt is sticky, exit_code follows the last store.
    do_req(1'b1, BASE + 32'h8, 32'h0, rd, er);
    check("halt_set", 32'(halt), 32'd1);
    check("exit_zero", exit_code, 32'd0);
    do_req(1'b1, BASE + 32'h8, 32'h7, rd, er);
    check("exit_seven", exit_code, 32'd7);
    check("halt_sticky", 32'(halt), 32'd1);
    do_req(1'b0, BASE + 32'h8, 32'h0, rd, er);
    check("exit_load", rd, 32'd7);

    // Access faults: unmapped load and misaligned store.
    do_req(1'b0, BASE + 32'h20, 32'h0, rd, er);
    check("unmapped_err", 32'(er), 32'd1);
    check("unmapped_rdata", rd, 32'd0);
    do_req(1'b1, BASE + 32'h6, 32'h55, rd, er);
    check("misaligned_err", 32'(er), 32'd1);
    check("misaligned_halt", 32'(halt), 32'd1);
    do_req(1'b0, BASE + 32'h4, 32'h0, rd, er);
    check("misaligned_status", rd, 32'h0000_0002);

    // Reset during the response cycle of an accepted TX store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h99;
    m_acc = 1'b0;
    for (int i = 0; i < 10 && !m_acc; i++) tick();
    check("pre_reset_accept", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0; req_we = 1'b0;
    do_reset();
    tick();
    check("post_reset_tx_valid", 32'(tx_valid), 32'd0);

    // Random traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = BASE + 32'($urandom_range(0, 3) * 4);
      else if (r == 7) a = BASE + 32'($urandom_range(0, 15));
      else if (r == 8) a = BASE + 32'($urandom_range(1, 8) * 16);
      else             a = $urandom;
      do_req(1'($urandom_range(0, 1)), a, $urandom, rd, er);
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
